twisted_ring_sequencer: RTL and testbench
=========================================

// Module: twisted_ring_sequencer
// PURPOSE
//   Parametrised N-bit shift-register sequencer: Johnson (2N states) or one-hot ring (N states).
//   Adds enable, up/down direction, parallel load, decoded phase index and a wrap pulse.
//   Drives multiphase strobes and timing slots in the control path.
//   count[] is glitch-free for direct decode.
// PARAMETERS
//   N     4   register width, N>=2
//   MODE  0   0 = Johnson (2N states), 1 = ring (N states, one-hot)
//   PW    derived = $clog2(2*N), width of phase; localparam, not overridable
// PORTS
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous, active-high reset
//   en        in   1   advance one state this cycle
//   dir       in   1   0 = forward (shift right), 1 = reverse (shift left)
//   load      in   1   parallel load of load_val
//   load_val  in   N   value to load
//   count     out  N   sequencer state, registered
//   phase     out  PW  state index, combinational decode of count, zero-extended
//   tc        out  1   wrap pulse, registered, 1 cycle
//   err       out  1   illegal-state correction pulse, registered (see CONFIGURATION)
// BEHAVIOUR
//   Reset: clock is clk; reset is synchronous, active-high, and has priority over all other inputs.
//   Reset values: count=0 (MODE 0) or 1<<(N-1) (MODE 1); phase=0; tc=0; err=0.
//   Per-edge priority: reset > load > self-correct (if compiled) > en step > hold.
//   Johnson step:
//     fwd: count <= {~count[0], count[N-1:1]}
//     rev: count <= {count[N-2:0], ~count[N-1]}
//     N=4 fwd sequence: 0000,1000,1100,1110,1111,0111,0011,0001, then 0000
//   Ring step:
//     fwd: count <= {count[0], count[N-1:1]}
//     rev: count <= {count[N-2:0], count[N-1]}
//     N=4 fwd sequence: 1000,0100,0010,0001, then 1000
//   Phase decode, Johnson (k = popcount(count)):
//     phase = k if count[N-1]==1 or count==0; else phase = 2N-k
//   Phase decode, ring: phase = N-1-(index of the set bit).
//   fwd step increments phase; rev step decrements phase; wraps modulo S (S = 2N or N).
//   Phase decode is defined for legal states only; an illegal count gives don't-care phase.
//   tc:
//     =1 on the edge where an en step wraps (fwd: S-1 -> 0, rev: 0 -> S-1)
//     =0 after reset, load, hold, correction, and any non-wrapping step
//   Latency:
//     count/tc update on the same edge as the accepted step
//     phase follows count combinationally, 0 cycles
//   dir may change on any cycle. It takes effect on the next step and needs no realignment.
//   load with en=1 in the same cycle: load wins, no step, tc=0.
//   load_val is taken verbatim. Legality is checked only when self-correct is compiled in.
//   Reset mid-sequence: next edge returns to the reset state; tc and err are cleared.
// CONFIGURATION
//   Macro: TRC_SELF_CORRECT_EN
//   Defined:
//     Combinational legality check on count:
//       Johnson: at most one adjacent-bit transition in count
//       ring: popcount == 1
//     If count is illegal and load=0, the next edge forces the reset state (en ignored), with err=1 for 1 cycle, tc=0.
//     The illegal value is therefore visible for exactly one cycle.
//   Undefined:
//     No checker logic is built and err is tied to 0.
//     Illegal states shift by the normal rules; Johnson stays in a parasitic loop.
//   The port list is identical in both builds.
// TESTING
//   Bench runs N=4 for both MODE values, with and without TRC_SELF_CORRECT_EN.
//   1 MODE0: reset, then en=1 dir=0 for 8 cycles
//       -> count 1000,1100,1110,1111,0111,0011,0001,0000
//       -> phase 1..7,0
//       -> tc=1 only with the final 0000
//   2 MODE0: from 0000, en=1 dir=1 for 2 cycles
//       -> count 0001 (phase 7, tc=1), then 0011 (phase 6, tc=0)
//   3 MODE0: en=0 for 3 cycles -> count held; then load=1, en=1, load_val=1100
//       -> count 1100, phase 2, tc=0
//   4 MODE0: reset=1 while count=1110 and en=1
//       -> count 0000, phase 0, tc=0, err=0 on the next edge
//   5 MODE0: load 1010
//       macro defined:   -> 1010 for 1 cycle, then 0000 with err=1 for 1 cycle
//       macro undefined: -> 1010, 1101, 0110, 1011, ..., err=0 throughout
//   6 MODE1: reset -> 1000; en=1 dir=0 for 4 cycles
//       -> 0100,0010,0001,1000, tc=1 with the final 1000
//       -> then dir=1 for 1 cycle gives 0001, phase 3, tc=1

Source files
------------

// File: rtl/twisted_ring_sequencer_if.sv
// twisted_ring_sequencer_if: control and status bundle of the twisted ring sequencer
interface twisted_ring_sequencer_if #(parameter int N = 4);
  localparam int PW = $clog2(2*N);
  logic en;
  logic dir;
  logic load;
  logic [N-1:0] load_val;
  logic [N-1:0] count;
  logic [PW-1:0] phase;
  logic tc;
  logic err;
  modport master (output en, dir, load, load_val, input count, phase, tc, err);
  modport slave (input en, dir, load, load_val, output count, phase, tc, err);
endinterface

// File: rtl/twisted_ring_sequencer.sv
// twisted_ring_sequencer: Johnson/one-hot ring sequencer with phase decode and wrap pulse
// Optional illegal-state self-correction is built when TRC_SELF_CORRECT_EN is defined.
module twisted_ring_sequencer #(
  parameter int N = 4,
  parameter int MODE = 0
) (
  input logic clk,
  input logic reset,
  twisted_ring_sequencer_if.slave bus
);
  localparam int PW = $clog2(2*N);
  localparam int S = (MODE != 0) ? N : 2*N;
  localparam logic [N-1:0] RST_VAL = (MODE != 0) ? {1'b1, {(N-1){1'b0}}} : '0;
  logic [N-1:0] count, fwd, rev, count_d;
  logic [PW-1:0] phase, ph_j, ph_r;
  logic tc, tc_d, wrap, fix;
  int idx;
  // Johnson phase counts ones while filling from the MSB, then counts down while draining
  always_comb begin
    idx = 0;
    for (int i = 0; i < N; i++) if (count[i]) idx = i;
    ph_r = PW'(N - 1 - idx);
    ph_j = (count[N-1] || count == '0) ? PW'($countones(count)) : PW'(2*N - $countones(count));
    phase = (MODE != 0) ? ph_r : ph_j;
  end
  assign fwd = {(MODE != 0) ? count[0] : ~count[0], count[N-1:1]};
  assign rev = {count[N-2:0], (MODE != 0) ? count[N-1] : ~count[N-1]};
  assign wrap = bus.dir ? (phase == '0) : (phase == PW'(S - 1));
`ifdef TRC_SELF_CORRECT_EN
  logic illegal, err;
  int trans;
  always_comb begin
    trans = 0;
    for (int i = 0; i < N - 1; i++) trans += int'(count[i] ^ count[i+1]);
    illegal = (MODE != 0) ? ($countones(count) != 1) : (trans > 1);
  end
  always_ff @(posedge clk) err <= !reset && !bus.load && illegal;
  assign fix = illegal;
  assign bus.err = err;
`else
  assign fix = 1'b0;
  assign bus.err = 1'b0;
`endif
  assign count_d = bus.load ? bus.load_val : fix ? RST_VAL : bus.en ? (bus.dir ? rev : fwd) : count;
  assign tc_d = !bus.load && !fix && bus.en && wrap;
  always_ff @(posedge clk) begin
    count <= reset ? RST_VAL : count_d;
    tc <= !reset && tc_d;
  end
  assign bus.count = count;
  assign bus.phase = phase;
  assign bus.tc = tc;
endmodule

// File: tb/tb_twisted_ring_sequencer.sv
// tb_twisted_ring_sequencer: directed and random checks of both modes against a phase-index model
module tb_twisted_ring_sequencer;
  localparam int N = 4;
`ifdef TRC_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic dir = 1'b0;
  logic load = 1'b0;
  logic [N-1:0] load_val = '0;
  int ncmp = 0;
  int nerr = 0;
  int mp [2];
  logic [N-1:0] mv [2];
  logic mtc [2];
  logic merr [2];
  bit ok_tc [2];

  always #5 clk = ~clk;

  twisted_ring_sequencer_if #(.N(N)) b0 ();
  twisted_ring_sequencer_if #(.N(N)) b1 ();
  assign b0.en = en;
  assign b0.dir = dir;
  assign b0.load = load;
  assign b0.load_val = load_val;
  assign b1.en = en;
  assign b1.dir = dir;
  assign b1.load = load;
  assign b1.load_val = load_val;

  twisted_ring_sequencer #(.N(N), .MODE(0)) d0 (.clk(clk), .reset(reset), .bus(b0.slave));
  twisted_ring_sequencer #(.N(N), .MODE(1)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));

  function automatic int states(int m);
    return (m != 0) ? N : 2*N;
  endfunction

  // Code word for phase p: Johnson fills ones from the MSB then drains them; ring is one-hot from the MSB
  function automatic logic [N-1:0] code(int m, int p);
    logic [N-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (m != 0) r[N-1-j] = (p == j);
      else r[N-1-j] = (p > j) && (p <= j + N);
    return r;
  endfunction

  function automatic int lookup(int m, logic [N-1:0] v);
    for (int p = 0; p < states(m); p++) if (code(m, p) == v) return p;
    return -1;
  endfunction

  task automatic model(int m);
    int s;
    logic feed;
    s = states(m);
    mtc[m] = 1'b0;
    merr[m] = 1'b0;
    ok_tc[m] = 1'b1;
    if (reset) begin
      mp[m] = 0;
      mv[m] = code(m, 0);
    end else if (load) begin
      mv[m] = load_val;
      mp[m] = lookup(m, load_val);
    end else if (SC && mp[m] < 0) begin
      mp[m] = 0;
      mv[m] = code(m, 0);
      merr[m] = 1'b1;
    end else if (en) begin
      if (mp[m] >= 0) begin
        mtc[m] = dir ? (mp[m] == 0) : (mp[m] == s - 1);
        mp[m] = dir ? (mp[m] + s - 1) % s : (mp[m] + 1) % s;
        mv[m] = code(m, mp[m]);
      end else begin
        ok_tc[m] = 1'b0;
        if (dir) begin
          feed = (m != 0) ? mv[m][N-1] : ~mv[m][N-1];
          mv[m] = {mv[m][N-2:0], feed};
        end else begin
          feed = (m != 0) ? mv[m][0] : ~mv[m][0];
          mv[m] = {feed, mv[m][N-1:1]};
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check(int m);
    logic [N-1:0] c;
    logic [$clog2(2*N)-1:0] ph;
    logic t, e;
    c = (m != 0) ? b1.count : b0.count;
    ph = (m != 0) ? b1.phase : b0.phase;
    t = (m != 0) ? b1.tc : b0.tc;
    e = (m != 0) ? b1.err : b0.err;
    chk($sformatf("m%0d count", m), 32'(c), 32'(mv[m]));
    if (mp[m] >= 0) chk($sformatf("m%0d phase", m), 32'(ph), 32'(mp[m]));
    if (ok_tc[m]) chk($sformatf("m%0d tc", m), 32'(t), 32'(mtc[m]));
    chk($sformatf("m%0d err", m), 32'(e), 32'(merr[m]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check(0);
    check(1);
  endtask

  initial begin
    mp[0] = 0;
    mp[1] = 0;
    mv[0] = '0;
    mv[1] = '0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    en = 1'b1;
    dir = 1'b0;
    repeat (8) cycle();
    chk("wrap fwd count", 32'(b0.count), 32'h0);
    chk("wrap fwd tc", 32'(b0.tc), 32'h1);
    dir = 1'b1;
    cycle();
    chk("wrap rev phase", 32'(b0.phase), 32'h7);
    cycle();
    en = 1'b0;
    repeat (3) cycle();
    load = 1'b1;
    en = 1'b1;
    load_val = 4'b1100;
    cycle();
    chk("load count", 32'(b0.count), 32'hc);
    load = 1'b0;
    dir = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    chk("reset mid count", 32'(b0.count), 32'h0);
    reset = 1'b0;
    load = 1'b1;
    load_val = 4'b1010;
    cycle();
    load = 1'b0;
    repeat (4) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (4) cycle();
    chk("ring wrap tc", 32'(b1.tc), 32'h1);
    dir = 1'b1;
    cycle();
    chk("ring rev count", 32'(b1.count), 32'h1);
    chk("ring rev phase", 32'(b1.phase), 32'h3);
    repeat (500) begin
      reset = ($urandom % 50) == 0;
      load = ($urandom % 8) == 0;
      load_val = ($urandom % 2) ? code(int'($urandom % 2), int'($urandom % 8)) : N'($urandom);
      en = ($urandom % 3) != 0;
      dir = 1'($urandom);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
